aurora_cmd_wbctl: RTL and testbench



---
 rtl/aurora_cmd_pkg.sv | 14 +
 rtl/aurora_cmd_wbctl.sv | 136 +++++++++++++
 tb/tb_aurora_cmd_wbctl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_cmd_pkg.sv
// Shared types and constants for the Aurora command Wishbone controller.
package aurora_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } wbctl_state_t;

  localparam int          CMD_READ_BIT         = 31;
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/aurora_cmd_wbctl.sv
// Runs split address/data command streams as single Wishbone classic cycles
// and returns read data (or a flagged error word) on a response stream.
module aurora_cmd_wbctl
  import aurora_cmd_pkg::*;
#(
  parameter int          ADDR_BITS      = 22,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [31:0]          s_cmd_addr_tdata,
  input  logic                 s_cmd_addr_tvalid,
  output logic                 s_cmd_addr_tready,
  input  logic [31:0]          s_cmd_data_tdata,
  input  logic                 s_cmd_data_tvalid,
  output logic                 s_cmd_data_tready,
  output logic [31:0]          m_resp_tdata,
  output logic                 m_resp_tuser,
  output logic                 m_resp_tvalid,
  input  logic                 m_resp_tready,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_BITS-1:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic [15:0]          err_count
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wbctl_state_t     state;
  logic             bus_active;
  logic [CNT_W-1:0] tmo_cnt;
  logic             is_read_cmd;
  logic             start_read;
  logic             start_write;
  logic             bus_term;
  logic             read_term;
  logic             unused_addr_bits;

  assign wb_cyc_o = bus_active;
  assign wb_stb_o = bus_active;
  assign wb_sel_o = 4'hF;

  // Address bits above the bus width and the read flag are not forwarded.
  assign unused_addr_bits = &{1'b0, s_cmd_addr_tdata};

  // A read only launches into an empty response register, so its data
  // always has somewhere to land even if the response path is stalled.
  assign is_read_cmd = s_cmd_addr_tdata[CMD_READ_BIT];
  assign start_read  = s_cmd_addr_tvalid & is_read_cmd & ~m_resp_tvalid;
  assign start_write = s_cmd_addr_tvalid & ~is_read_cmd & s_cmd_data_tvalid;

  assign bus_term  = wb_ack_i | wb_err_i | (tmo_cnt == CNT_LAST);
  assign read_term = (state == READ) & bus_term;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state             <= IDLE;
      bus_active        <= 1'b0;
      wb_we_o           <= 1'b0;
      wb_adr_o          <= '0;
      wb_dat_o          <= '0;
      s_cmd_addr_tready <= 1'b0;
      s_cmd_data_tready <= 1'b0;
      tmo_cnt           <= '0;
      err_count         <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_cmd_addr_tready <= 1'b0;
          s_cmd_data_tready <= 1'b0;
          if (start_read) begin
            state      <= READ;
            bus_active <= 1'b1;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= s_cmd_addr_tdata[ADDR_BITS-1:0];
            tmo_cnt    <= '0;
          end else if (start_write) begin
            state      <= WRITE;
            bus_active <= 1'b1;
            wb_we_o    <= 1'b1;
            wb_adr_o   <= s_cmd_addr_tdata[ADDR_BITS-1:0];
            wb_dat_o   <= s_cmd_data_tdata;
            tmo_cnt    <= '0;
          end
        end
        WRITE, READ: begin
          if (bus_term) begin
            state             <= DONE;
            bus_active        <= 1'b0;
            wb_we_o           <= 1'b0;
            s_cmd_addr_tready <= 1'b1;
            s_cmd_data_tready <= (state == WRITE);
            // Ack wins over err/timeout; only non-ack endings are counted.
            if (!wb_ack_i && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'd1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          s_cmd_addr_tready <= 1'b0;
          s_cmd_data_tready <= 1'b0;
          state             <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Response register: filled by a finishing read, drained by the consumer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_resp_tvalid <= 1'b0;
      m_resp_tdata  <= '0;
      m_resp_tuser  <= 1'b0;
    end else if (read_term) begin
      m_resp_tvalid <= 1'b1;
      m_resp_tdata  <= wb_ack_i ? wb_dat_i : TIMEOUT_DATA;
      m_resp_tuser  <= ~wb_ack_i;
    end else if (m_resp_tvalid && m_resp_tready) begin
      m_resp_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aurora_cmd_wbctl.sv
// Directed cycle-by-cycle bench for aurora_cmd_wbctl; inputs change and
// outputs are sampled on the falling clock edge.
module tb_aurora_cmd_wbctl;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_cmd_addr_tdata = '0;
  logic        s_cmd_addr_tvalid = 1'b0;
  logic        s_cmd_addr_tready;
  logic [31:0] s_cmd_data_tdata = '0;
  logic        s_cmd_data_tvalid = 1'b0;
  logic        s_cmd_data_tready;
  logic [31:0] m_resp_tdata;
  logic        m_resp_tuser;
  logic        m_resp_tvalid;
  logic        m_resp_tready = 1'b0;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  aurora_cmd_wbctl #(
    .ADDR_BITS(22),
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_DATA(32'hFFFF_FFFF)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_cmd_addr_tdata(s_cmd_addr_tdata),
    .s_cmd_addr_tvalid(s_cmd_addr_tvalid),
    .s_cmd_addr_tready(s_cmd_addr_tready),
    .s_cmd_data_tdata(s_cmd_data_tdata),
    .s_cmd_data_tvalid(s_cmd_data_tvalid),
    .s_cmd_data_tready(s_cmd_data_tready),
    .m_resp_tdata(m_resp_tdata),
    .m_resp_tuser(m_resp_tuser),
    .m_resp_tvalid(m_resp_tvalid),
    .m_resp_tready(m_resp_tready),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_cyc: got %b expected 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stb: got %b expected 0", wb_stb_o); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b expected 0", wb_we_o); end
    checks++; if (wb_sel_o !== 4'hF) begin errors++; $display("[TB] FAIL rst_sel: got %h expected f", wb_sel_o); end
    checks++; if (wb_adr_o !== 22'h0) begin errors++; $display("[TB] FAIL rst_adr: got %h expected 0", wb_adr_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_dat: got %h expected 0", wb_dat_o); end
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b00) begin errors++; $display("[TB] FAIL rst_tready: got %b expected 00", {s_cmd_addr_tready, s_cmd_data_tready}); end
    checks++; if ({m_resp_tvalid, m_resp_tuser} !== 2'b00) begin errors++; $display("[TB] FAIL rst_resp_flags: got %b expected 00", {m_resp_tvalid, m_resp_tuser}); end
    checks++; if (m_resp_tdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h expected 0", m_resp_tdata); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("[TB] FAIL rst_err_count: got %0d expected 0", err_count); end
    areset = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_write();
    s_cmd_addr_tdata = 32'h0000_0010; s_cmd_addr_tvalid = 1'b1;
    s_cmd_data_tdata = 32'hA5A5_A5A5; s_cmd_data_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin errors++; $display("[TB] FAIL wr_ctrl: got %b expected 111", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if (wb_adr_o !== 22'h10) begin errors++; $display("[TB] FAIL wr_adr: got %h expected 10", wb_adr_o); end
    checks++; if (wb_dat_o !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL wr_dat: got %h expected a5a5a5a5", wb_dat_o); end
    checks++; if (s_cmd_addr_tready !== 1'b0) begin errors++; $display("[TB] FAIL wr_early_tready: got %b expected 0", s_cmd_addr_tready); end
    @(negedge aclk);
    checks++; if (wb_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_cyc_hold: got %b expected 1", wb_cyc_o); end
    wb_ack_i = 1'b1;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("[TB] FAIL wr_done_ctrl: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b11) begin errors++; $display("[TB] FAIL wr_tready: got %b expected 11", {s_cmd_addr_tready, s_cmd_data_tready}); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b00) begin errors++; $display("[TB] FAIL wr_tready_pulse: got %b expected 00", {s_cmd_addr_tready, s_cmd_data_tready}); end
    checks++; if (m_resp_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_resp: got %b expected 0", m_resp_tvalid); end
  endtask

  task automatic test_read();
    s_cmd_addr_tdata = 32'h8000_0020; s_cmd_addr_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_we_o} !== 2'b10) begin errors++; $display("[TB] FAIL rd_ctrl: got %b expected 10", {wb_cyc_o, wb_we_o}); end
    checks++; if (wb_adr_o !== 22'h20) begin errors++; $display("[TB] FAIL rd_adr: got %h expected 20", wb_adr_o); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b10) begin errors++; $display("[TB] FAIL rd_tready: got %b expected 10", {s_cmd_addr_tready, s_cmd_data_tready}); end
    checks++; if ({m_resp_tvalid, m_resp_tuser} !== 2'b10) begin errors++; $display("[TB] FAIL rd_resp_flags: got %b expected 10", {m_resp_tvalid, m_resp_tuser}); end
    checks++; if (m_resp_tdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_resp_data: got %h expected 12345678", m_resp_tdata); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; m_resp_tready = 1'b1;
    @(negedge aclk);
    m_resp_tready = 1'b0;
    checks++; if (m_resp_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_resp_drain: got %b expected 0", m_resp_tvalid); end
  endtask

  task automatic test_back_to_back();
    int cyc_seen;
    s_cmd_addr_tdata = 32'h8000_0040; s_cmd_addr_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if (wb_adr_o !== 22'h40) begin errors++; $display("[TB] FAIL b2b_adr1: got %h expected 40", wb_adr_o); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if (m_resp_tdata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL b2b_resp1: got %h expected 11111111", m_resp_tdata); end
    @(negedge aclk);
    s_cmd_addr_tdata = 32'h8000_0044;
    cyc_seen = 0;
    repeat (4) begin
      @(negedge aclk);
      if (wb_cyc_o) cyc_seen++;
    end
    checks++; if (cyc_seen !== 0) begin errors++; $display("[TB] FAIL b2b_stall: got %0d cyc cycles expected 0", cyc_seen); end
    checks++; if ({m_resp_tvalid, m_resp_tdata} !== {1'b1, 32'h1111_1111}) begin errors++; $display("[TB] FAIL b2b_resp_held: got %b/%h expected 1/11111111", m_resp_tvalid, m_resp_tdata); end
    m_resp_tready = 1'b1;
    @(negedge aclk);
    m_resp_tready = 1'b0;
    checks++; if ({wb_cyc_o, m_resp_tvalid} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_no_bypass: got %b expected 00", {wb_cyc_o, m_resp_tvalid}); end
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_adr_o} !== {1'b1, 22'h44}) begin errors++; $display("[TB] FAIL b2b_second: got %b/%h expected 1/44", wb_cyc_o, wb_adr_o); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h2222_2222;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({m_resp_tvalid, m_resp_tdata} !== {1'b1, 32'h2222_2222}) begin errors++; $display("[TB] FAIL b2b_resp2: got %b/%h expected 1/22222222", m_resp_tvalid, m_resp_tdata); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; m_resp_tready = 1'b1;
    @(negedge aclk);
    m_resp_tready = 1'b0;
  endtask

  task automatic test_timeout();
    int stb_seen;
    s_cmd_addr_tdata = 32'h8000_0030; s_cmd_addr_tvalid = 1'b1;
    stb_seen = 0;
    repeat (16) begin
      @(negedge aclk);
      if (wb_stb_o) stb_seen++;
    end
    checks++; if (stb_seen !== 16) begin errors++; $display("[TB] FAIL tmo_stb_len: got %0d expected 16", stb_seen); end
    @(negedge aclk);
    checks++; if ({wb_stb_o, s_cmd_addr_tready} !== 2'b01) begin errors++; $display("[TB] FAIL tmo_done: got %b expected 01", {wb_stb_o, s_cmd_addr_tready}); end
    checks++; if ({m_resp_tvalid, m_resp_tuser, m_resp_tdata} !== {2'b11, 32'hFFFF_FFFF}) begin errors++; $display("[TB] FAIL tmo_resp: got %b%b/%h expected 11/ffffffff", m_resp_tvalid, m_resp_tuser, m_resp_tdata); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("[TB] FAIL tmo_err_count: got %0d expected 1", err_count); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; m_resp_tready = 1'b1;
    @(negedge aclk);
    m_resp_tready = 1'b0;
  endtask

  task automatic test_bus_error();
    s_cmd_addr_tdata = 32'h8000_0070; s_cmd_addr_tvalid = 1'b1;
    @(negedge aclk);
    wb_err_i = 1'b1;
    @(negedge aclk);
    wb_err_i = 1'b0;
    checks++; if ({m_resp_tvalid, m_resp_tuser, m_resp_tdata} !== {2'b11, 32'hFFFF_FFFF}) begin errors++; $display("[TB] FAIL err_resp: got %b%b/%h expected 11/ffffffff", m_resp_tvalid, m_resp_tuser, m_resp_tdata); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("[TB] FAIL err_count_read: got %0d expected 2", err_count); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; m_resp_tready = 1'b1;
    @(negedge aclk);
    m_resp_tready = 1'b0;
    s_cmd_addr_tdata = 32'h0000_0074; s_cmd_addr_tvalid = 1'b1;
    s_cmd_data_tdata = 32'h5555_AAAA; s_cmd_data_tvalid = 1'b1;
    @(negedge aclk);
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    @(negedge aclk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    checks++; if (err_count !== 16'd2) begin errors++; $display("[TB] FAIL err_ack_priority: got %0d expected 2", err_count); end
    checks++; if ({s_cmd_data_tready, m_resp_tvalid} !== 2'b10) begin errors++; $display("[TB] FAIL err_write_done: got %b expected 10", {s_cmd_data_tready, m_resp_tvalid}); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
  endtask

  task automatic test_delayed_data();
    int cyc_seen;
    s_cmd_addr_tdata = 32'h0000_0050; s_cmd_addr_tvalid = 1'b1;
    s_cmd_data_tdata = 32'hDEAD_BEEF; s_cmd_data_tvalid = 1'b0;
    cyc_seen = 0;
    repeat (5) begin
      @(negedge aclk);
      if (wb_cyc_o || s_cmd_addr_tready) cyc_seen++;
    end
    checks++; if (cyc_seen !== 0) begin errors++; $display("[TB] FAIL dly_wait: got %0d active cycles expected 0", cyc_seen); end
    s_cmd_data_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== {2'b11, 22'h50, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL dly_write: got %b%b/%h/%h expected 11/50/deadbeef", wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o); end
    wb_ack_i = 1'b1;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b11) begin errors++; $display("[TB] FAIL dly_tready: got %b expected 11", {s_cmd_addr_tready, s_cmd_data_tready}); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Reset while a read strobes the bus.
    s_cmd_addr_tdata = 32'h8000_0060; s_cmd_addr_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if (wb_stb_o !== 1'b1) begin errors++; $display("[TB] FAIL rstm_stb_before: got %b expected 1", wb_stb_o); end
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    checks++; if ({wb_cyc_o, wb_stb_o, m_resp_tvalid, s_cmd_addr_tready} !== 4'b0000) begin errors++; $display("[TB] FAIL rstm_outputs: got %b expected 0000", {wb_cyc_o, wb_stb_o, m_resp_tvalid, s_cmd_addr_tready}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL rstm_err_count: got %0d expected 0", err_count); end
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_adr_o} !== {1'b1, 22'h60}) begin errors++; $display("[TB] FAIL rstm_reexec: got %b/%h expected 1/60", wb_cyc_o, wb_adr_o); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({m_resp_tvalid, m_resp_tdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("[TB] FAIL rstm_resp: got %b/%h expected 1/0badf00d", m_resp_tvalid, m_resp_tdata); end
    @(negedge aclk);
    // Reset during a write while that read response is still pending.
    s_cmd_addr_tdata = 32'h0000_0064; s_cmd_data_tdata = 32'h0102_0304; s_cmd_data_tvalid = 1'b1;
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_we_o, m_resp_tvalid} !== 3'b111) begin errors++; $display("[TB] FAIL rstm_wr_start: got %b expected 111", {wb_cyc_o, wb_we_o, m_resp_tvalid}); end
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    checks++; if ({wb_cyc_o, m_resp_tvalid, s_cmd_data_tready} !== 3'b000) begin errors++; $display("[TB] FAIL rstm_discard: got %b expected 000", {wb_cyc_o, m_resp_tvalid, s_cmd_data_tready}); end
    @(negedge aclk);
    checks++; if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== {2'b11, 22'h64, 32'h0102_0304}) begin errors++; $display("[TB] FAIL rstm_wr_reexec: got %b%b/%h/%h expected 11/64/01020304", wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o); end
    wb_ack_i = 1'b1;
    @(negedge aclk);
    wb_ack_i = 1'b0;
    checks++; if ({s_cmd_addr_tready, s_cmd_data_tready} !== 2'b11) begin errors++; $display("[TB] FAIL rstm_wr_tready: got %b expected 11", {s_cmd_addr_tready, s_cmd_data_tready}); end
    @(negedge aclk);
    s_cmd_addr_tvalid = 1'b0; s_cmd_data_tvalid = 1'b0;
    @(negedge aclk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_bus_error();
    test_delayed_data();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
